mac_result_drain: RTL and testbench

//   Reader/consumer for the MAC array's packed per-row result bus. Captures one packed

---
 rtl/mac_result_drain.sv | 124 ++++++++++++
 tb/tb_mac_result_drain.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_drain.sv
// mac_result_drain
//   Drains packed per-row result vectors from the MAC array into a 2-slot
//   ping-pong buffer. Each vector goes out one word per handshake, row 0 first,
//   on a valid/ready stream.
//   Optional feature macro: MAC_DRAIN_RELU_EN. When it is defined, negative
//   words (MSB set) are shown as zero on out_data_o. Stored data is unchanged.
module mac_result_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int ARRAY_ROWS = 8,
  parameter int ROW_IDX_W  = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             res_valid_i,
  input  logic [DATA_WIDTH*ARRAY_ROWS-1:0] res_data_i,
  output logic                             res_ready_o,
  output logic                             out_valid_o,
  output logic [DATA_WIDTH-1:0]            out_data_o,
  output logic [ROW_IDX_W-1:0]             out_row_o,
  output logic                             out_last_o,
  input  logic                             out_ready_i,
  output logic [15:0]                      vec_cnt_o
);

  // Occupancy encoding: number of slots holding an undrained vector
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] HALF  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ARRAY_ROWS - 1);

  logic [1:0]                            occupancy;
  logic [1:0]                            occupancy_next;
  logic                                  wr_ptr;
  logic                                  rd_ptr;
  logic [ROW_IDX_W-1:0]                  row_idx;
  logic [15:0]                           vec_cnt;
  logic [ARRAY_ROWS-1:0][DATA_WIDTH-1:0] slot [2];

  logic                                  capture;
  logic                                  transfer;
  logic                                  at_last;
  logic                                  vec_done;
  logic [DATA_WIDTH-1:0]                 word;

  // Handshake decodes. Ready comes only from registered occupancy, so there is
  // no combinational path from out_ready_i to res_ready_o.
  assign res_ready_o = (occupancy != FULL);
  assign out_valid_o = (occupancy != EMPTY);
  assign capture     = res_valid_i & res_ready_o;
  assign transfer    = out_valid_o & out_ready_i;
  assign at_last     = (row_idx == LAST_ROW);
  assign vec_done    = transfer & at_last;

  assign out_row_o   = row_idx;
  assign out_last_o  = out_valid_o & at_last;
  assign vec_cnt_o   = vec_cnt;

  // The slot storage has no reset. Its contents stay hidden until a capture
  // makes them valid.
  always_ff @(posedge clk) begin
    if (capture) begin
      slot[wr_ptr] <= res_data_i;
    end
  end

  // Output word mux. The word is forced to zero while nothing valid is held.
  always_comb begin
    word = slot[rd_ptr][row_idx];
    out_data_o = '0;
    if (out_valid_o) begin
`ifdef MAC_DRAIN_RELU_EN
      out_data_o = word[DATA_WIDTH-1] ? '0 : word;
`else
      out_data_o = word;
`endif
    end
  end

  // Occupancy next-state. A capture and a vec_done in the same cycle cancel out.
  always_comb begin
    occupancy_next = occupancy;
    case (occupancy)
      EMPTY: begin
        if (capture) occupancy_next = HALF;
      end
      HALF: begin
        if (capture && !vec_done)      occupancy_next = FULL;
        else if (!capture && vec_done) occupancy_next = EMPTY;
      end
      FULL: begin
        if (vec_done) occupancy_next = HALF;
      end
      default: occupancy_next = EMPTY;
    endcase
  end

  // Pointers, row counter and the drained-vector count. A reset drops any
  // partially drained vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occupancy <= EMPTY;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      row_idx   <= '0;
      vec_cnt   <= '0;
    end else begin
      occupancy <= occupancy_next;
      if (capture) begin
        wr_ptr <= ~wr_ptr;
      end
      if (transfer) begin
        if (at_last) begin
          row_idx <= '0;
          rd_ptr  <= ~rd_ptr;
          vec_cnt <= vec_cnt + 16'd1;
        end else begin
          row_idx <= row_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_result_drain.sv
// Testbench for mac_result_drain (DATA_WIDTH=32, ARRAY_ROWS=8).
// A scoreboard queue is filled with the expected words whenever a vector is
// captured. It is compared and popped as words leave the DUT.
module tb_mac_result_drain;

  localparam int DW   = 32;
  localparam int ROWS = 8;
  localparam int RW   = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              res_valid_i;
  logic [DW*ROWS-1:0] res_data_i;
  logic              res_ready_o;
  logic              out_valid_o;
  logic [DW-1:0]     out_data_o;
  logic [RW-1:0]     out_row_o;
  logic              out_last_o;
  logic              out_ready_i;
  logic [15:0]       vec_cnt_o;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [RW-1:0] row;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   passes  = 0;
  int   fails   = 0;
  int   exp_vec = 0;
  bit   rand_done;

  always #5 clk = ~clk;

  mac_result_drain #(.DATA_WIDTH(DW), .ARRAY_ROWS(ROWS), .ROW_IDX_W(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .res_valid_i(res_valid_i),
    .res_data_i (res_data_i),
    .res_ready_o(res_ready_o),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .out_row_o  (out_row_o),
    .out_last_o (out_last_o),
    .out_ready_i(out_ready_i),
    .vec_cnt_o  (vec_cnt_o)
  );

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] w);
`ifdef MAC_DRAIN_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [DW*ROWS-1:0] rand_vec();
    logic [DW*ROWS-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Offer one vector and hold it until it is captured. Called just after a rising edge.
  task automatic applyStimulus(input logic [DW*ROWS-1:0] v);
    bit ok = 0;
    res_valid_i = 1'b1;
    res_data_i  = v;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (res_ready_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("capture_timeout", res_ready_o, 1);
    @(posedge clk); #1;
    res_valid_i = 1'b0;
    res_data_i  = rand_vec();
  endtask

  task automatic waitDrain(input int limit);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: push expected words on capture, compare and pop on transfer,
  // and compare the drained-vector count.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_vec = 0;
    end else begin
      checkOutput("vec_cnt", vec_cnt_o, 64'(16'(exp_vec)));
      if (res_valid_i && res_ready_o) begin
        for (int r = 0; r < ROWS; r++)
          sb.push_back('{data: relu(res_data_i[r*DW +: DW]), row: RW'(r)});
      end
      if (out_valid_o) begin
        if (sb.size() == 0) begin
          checkOutput("valid_without_expected", out_valid_o, 0);
        end else begin
          checkOutput("data", out_data_o, sb[0].data);
          checkOutput("row",  out_row_o,  sb[0].row);
          checkOutput("last", out_last_o, (sb[0].row == RW'(ROWS-1)));
          if (out_ready_i) begin
            if (sb[0].row == RW'(ROWS-1)) exp_vec++;
            void'(sb.pop_front());
          end
        end
      end else begin
        checkOutput("idle_data", out_data_o, 0);
        checkOutput("idle_last", out_last_o, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW*ROWS-1:0] v;

    // Test 1: reset, then a single vector
    rst_n       = 1'b0;
    res_valid_i = 1'b0;
    res_data_i  = '0;
    out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_res_ready", res_ready_o, 1);
    checkOutput("rst_out_valid", out_valid_o, 0);
    checkOutput("rst_out_row",   out_row_o,   0);
    checkOutput("rst_out_last",  out_last_o,  0);
    checkOutput("rst_out_data",  out_data_o,  0);
    checkOutput("rst_vec_cnt",   vec_cnt_o,   0);
    @(posedge clk); #1;
    rst_n       = 1'b1;
    out_ready_i = 1'b1;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = 32'h100 + r;
    applyStimulus(v);
    @(negedge clk);
    checkOutput("t1_valid_after_capture", out_valid_o, 1);
    checkOutput("t1_first_data", out_data_o, 32'h100);
    waitDrain(50);
    @(negedge clk);
    checkOutput("t1_vec_cnt", vec_cnt_o, 1);

    // Test 2: two vectors fill the buffer, the third is held off
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    applyStimulus(rand_vec());
    applyStimulus(rand_vec());
    @(negedge clk);
    checkOutput("t2_full_ready", res_ready_o, 0);
    @(posedge clk); #1;
    res_valid_i = 1'b1;
    res_data_i  = rand_vec();
    repeat (3) @(negedge clk);
    checkOutput("t2_third_held", res_ready_o, 0);
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checkOutput("t2_no_gap", out_valid_o, 1);
      if (i == 8) checkOutput("t2_ready_before_done", res_ready_o, 0);
      if (i == 9) begin
        checkOutput("t2_ready_after_done", res_ready_o, 1);
        @(posedge clk); #1;
        res_valid_i = 1'b0;
      end
    end
    waitDrain(50);

    // Test 3: 100 random vectors with random downstream ready
    rand_done = 0;
    fork
      begin
        for (int n = 0; n < 100; n++) applyStimulus(rand_vec());
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready_i = 1'b1;
    waitDrain(100);

    // Test 4: capture and vec_done on the same edge while HALF
    out_ready_i = 1'b0;
    applyStimulus(rand_vec());
    out_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_row_o == 3'd6) break;
    end
    @(posedge clk); #1;
    v = rand_vec();
    res_valid_i = 1'b1;
    res_data_i  = v;
    @(negedge clk);
    checkOutput("t4_row7",  out_row_o,   7);
    checkOutput("t4_ready", res_ready_o, 1);
    @(posedge clk); #1;
    res_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("t4_valid", out_valid_o, 1);
    checkOutput("t4_half",  res_ready_o, 1);
    checkOutput("t4_row0",  out_row_o,   0);
    checkOutput("t4_data0", out_data_o,  relu(v[DW-1:0]));
    waitDrain(50);

    // Test 5: reset after three words of a vector
    applyStimulus(rand_vec());
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_row_o == 3'd2) break;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    checkOutput("t5_valid",   out_valid_o, 0);
    checkOutput("t5_ready",   res_ready_o, 1);
    checkOutput("t5_vec_cnt", vec_cnt_o,   0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    v = rand_vec();
    applyStimulus(v);
    @(negedge clk);
    checkOutput("t5_restart_row", out_row_o, 0);
    checkOutput("t5_restart_data", out_data_o, relu(v[DW-1:0]));
    waitDrain(50);

    // Test 6: sign-boundary words
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = 32'h200 + r;
    v[0*DW +: DW] = 32'hFFFF_FFFF;
    v[1*DW +: DW] = 32'h7FFF_FFFF;
    v[2*DW +: DW] = 32'h8000_0000;
    applyStimulus(v);
    waitDrain(50);

    checkOutput("final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
